// File: rtl/oam_dma_controller.sv
// rtl/oam_dma_controller.sv - OAM DMA sequencer and CPU/memory bus arbiter (FF46)
module oam_dma_controller #(
    parameter int          XFER_LEN     = 160,
    parameter logic [15:0] DMA_REG_ADDR = 16'hFF46
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_wren,
    input  logic [7:0]  cpu_data_in,
    output logic [7:0]  cpu_data_out,
    output logic [15:0] mem_addr,
    output logic        mem_wren,
    output logic [7:0]  mem_data_in,
    input  logic [7:0]  mem_data_out,
    output logic [7:0]  oam_dma_addr,
    output logic [7:0]  oam_dma_data,
    output logic        oam_dma_wren,
    output logic        dma_active,
    output logic [1:0]  m_phase
);

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    state_t      r_state;
    logic [1:0]  r_phase;
    logic [7:0]  r_dma_reg;
    logic [7:0]  r_idx;
    logic [7:0]  r_oam_addr;
    logic [7:0]  r_oam_data;
    logic        r_oam_wren;

    logic        w_reg_write;
    logic        w_hram;
    logic [7:0]  w_src_hi;
    logic [7:0]  w_idx_next;

    assign w_reg_write = cpu_wren && (cpu_addr == DMA_REG_ADDR) && (r_phase == 2'd3);
    assign w_hram      = (cpu_addr >= 16'hFF80) && (cpu_addr <= 16'hFFFE);
    // Pages above DF mirror down onto work RAM, as on the real hardware.
    assign w_src_hi    = (r_dma_reg > 8'hDF) ? (r_dma_reg - 8'h20) : r_dma_reg;
    assign w_idx_next  = r_idx + 8'd1;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_phase    <= 2'd0;
            r_dma_reg  <= 8'hFF;
            r_idx      <= 8'd0;
            r_oam_addr <= 8'd0;
            r_oam_data <= 8'd0;
            r_oam_wren <= 1'b0;
        end else begin
            r_phase    <= r_phase + 2'd1;
            r_oam_wren <= 1'b0;
            if (w_reg_write) begin
                r_dma_reg <= cpu_data_in;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_reg_write) begin
                        r_state <= S_ACTIVE;
                        r_idx   <= 8'd0;
                    end
                end
                S_ACTIVE: begin
                    // Source byte returns during phase 1; strobe it into OAM in phase 2.
                    if (r_phase == 2'd1) begin
                        r_oam_data <= mem_data_out;
                        r_oam_addr <= r_idx;
                        r_oam_wren <= 1'b1;
                    end
                    if (r_phase == 2'd3) begin
                        if (w_reg_write) begin
                            r_idx <= 8'd0;
                        end else if (r_idx == LAST_IDX) begin
                            r_state <= S_IDLE;
                            r_idx   <= 8'd0;
                        end else begin
                            r_idx <= w_idx_next;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_addr     = cpu_addr;
        mem_wren     = cpu_wren;
        cpu_data_out = mem_data_out;
        if (r_state == S_ACTIVE) begin
            if (!r_phase[1]) begin
                mem_addr = {w_src_hi, r_idx};
            end
            // CPU keeps only HRAM while the DMA owns the bus.
            mem_wren = cpu_wren && w_hram && (r_phase == 2'd3);
            if (!w_hram) begin
                cpu_data_out = 8'hFF;
            end
        end
        if (cpu_addr == DMA_REG_ADDR) begin
            cpu_data_out = r_dma_reg;
        end
    end

    assign mem_data_in  = cpu_data_in;
    assign oam_dma_addr = r_oam_addr;
    assign oam_dma_data = r_oam_data;
    assign oam_dma_wren = r_oam_wren;
    assign dma_active   = (r_state == S_ACTIVE);
    assign m_phase      = r_phase;

endmodule

// File: tb/tb_oam_dma_controller.sv
// tb/tb_oam_dma_controller.sv - scoreboard bench for oam_dma_controller
module tb_oam_dma_controller;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [15:0] cpu_addr;
    logic        cpu_wren;
    logic [7:0]  cpu_data_in;
    logic [7:0]  cpu_data_out;
    logic [15:0] mem_addr;
    logic        mem_wren;
    logic [7:0]  mem_data_in;
    logic [7:0]  mem_data_out;
    logic [7:0]  oam_dma_addr;
    logic [7:0]  oam_dma_data;
    logic        oam_dma_wren;
    logic        dma_active;
    logic [1:0]  m_phase;

    oam_dma_controller #(.XFER_LEN(160), .DMA_REG_ADDR(16'hFF46)) dut (
        .clock(clock), .reset_n(reset_n),
        .cpu_addr(cpu_addr), .cpu_wren(cpu_wren), .cpu_data_in(cpu_data_in),
        .cpu_data_out(cpu_data_out),
        .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out),
        .oam_dma_addr(oam_dma_addr), .oam_dma_data(oam_dma_data), .oam_dma_wren(oam_dma_wren),
        .dma_active(dma_active), .m_phase(m_phase)
    );

    always #5 clock = ~clock;

    // Memory block model: registered read, one clock latency.
    logic [7:0] mem [0:65535];
    bit         loaded = 1'b0;
    always @(posedge clock) begin
        if (!loaded) begin
            for (int i = 0; i < 160; i++) begin
                mem[16'hC000 + 16'(i)] <= 8'(i) ^ 8'h5A;
                mem[16'hC100 + 16'(i)] <= 8'(i) ^ 8'hA5;
            end
            loaded <= 1'b1;
        end else if (mem_wren) begin
            mem[mem_addr] <= mem_data_in;
        end
        mem_data_out <= mem[mem_addr];
    end

    int          n_cmp = 0;
    int          n_fail = 0;
    int          n_strobe = 0;
    int          act_cnt = 0;
    int          last_len = 0;
    logic [15:0] exp_q [$];
    logic [7:0]  oam [0:255];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic monitor_loop();
        logic [15:0] e;
        forever begin
            @(negedge clock);
            if (oam_dma_wren) begin
                n_strobe++;
                oam[oam_dma_addr] = oam_dma_data;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL oam_unexpected: got addr=%0d data=%h expected no strobe",
                             oam_dma_addr, oam_dma_data);
                end else begin
                    e = exp_q.pop_front();
                    check("oam_write", {oam_dma_addr, oam_dma_data}, e);
                end
            end
            if (dma_active) begin
                act_cnt++;
            end else if (act_cnt != 0) begin
                last_len = act_cnt;
                act_cnt  = 0;
            end
        end
    endtask

    // Expected strobe stream for n bytes starting at index 0 from page hi.
    task automatic push_xfer(input logic [7:0] hi, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({8'(i), 8'(i) ^ ((hi == 8'hC0) ? 8'h5A : 8'hA5)});
        end
    endtask

    task automatic cpu_cycle(input logic [15:0] a, input logic w, input logic [7:0] d,
                             output logic [7:0] rd);
        int g = 0;
        while (m_phase != 2'd0 && g < 8) begin
            @(negedge clock);
            g++;
        end
        if (g >= 8) check("phase_align", 16'(m_phase), 16'd0);
        cpu_addr    = a;
        cpu_wren    = w;
        cpu_data_in = d;
        repeat (3) @(negedge clock);
        rd = cpu_data_out;
        @(negedge clock);
        cpu_wren = 1'b0;
        cpu_addr = 16'h0000;
    endtask

    task automatic idle_cycles(input int n);
        logic [7:0] rd;
        for (int i = 0; i < n; i++) cpu_cycle(16'h0000, 1'b0, 8'h00, rd);
    endtask

    task automatic wait_idle(input string name, input int exp_len);
        int g = 0;
        while (dma_active && g < 3000) begin
            @(negedge clock);
            g++;
        end
        if (g >= 3000) check({name, "_timeout"}, 16'd1, 16'd0);
        @(negedge clock);
        check({name, "_active_len"}, 16'(last_len), 16'(exp_len));
        check({name, "_queue_empty"}, 16'(exp_q.size()), 16'd0);
    endtask

    initial begin
        logic [7:0] rd;
        int         s0;
        fork
            monitor_loop();
        join_none
        reset_n     = 1'b0;
        cpu_addr    = 16'hFF46;
        cpu_wren    = 1'b0;
        cpu_data_in = 8'h00;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_m_phase", 16'(m_phase), 16'd0);
        check("rst_dma_active", 16'(dma_active), 16'd0);
        check("rst_oam_wren", 16'(oam_dma_wren), 16'd0);
        check("rst_oam_addr", 16'(oam_dma_addr), 16'd0);
        check("rst_oam_data", 16'(oam_dma_data), 16'd0);
        check("rst_ff46", 16'(cpu_data_out), 16'h00FF);
        reset_n = 1'b1;
        @(negedge clock);
        check("post_rst_m_phase", 16'(m_phase), 16'd1);
        cpu_addr = 16'h0000;

        // Basic transfer with CPU isolation checks while active
        push_xfer(8'hC0, 160);
        cpu_cycle(16'hFF46, 1'b1, 8'hC0, rd);
        check("start_active", 16'(dma_active), 16'd1);
        check("start_phase", 16'(m_phase), 16'd0);
        cpu_cycle(16'hC010, 1'b0, 8'h00, rd);
        check("iso_read_c010", 16'(rd), 16'h00FF);
        cpu_cycle(16'hC020, 1'b1, 8'h77, rd);
        cpu_cycle(16'hFF90, 1'b1, 8'h33, rd);
        cpu_cycle(16'hFF90, 1'b0, 8'h00, rd);
        check("iso_hram_rd", 16'(rd), 16'h0033);
        cpu_cycle(16'hFF46, 1'b0, 8'h00, rd);
        check("active_ff46_rd", 16'(rd), 16'h00C0);
        wait_idle("basic", 640);
        check("c020_kept", 16'(mem[16'hC020]), 16'h007A);
        check("basic_oam0", 16'(oam[0]), 16'h005A);
        check("basic_oam159", 16'(oam[159]), 16'h00C5);

        // Source page clamp: E1 reads C1xx
        push_xfer(8'hC1, 160);
        cpu_cycle(16'hFF46, 1'b1, 8'hE1, rd);
        cpu_cycle(16'hFF46, 1'b0, 8'h00, rd);
        check("clamp_ff46_rd", 16'(rd), 16'h00E1);
        wait_idle("clamp", 640);
        check("clamp_oam100", 16'(oam[100]), 16'h00C1);

        // Restart at idx 50: bytes 0..50 from C0, then full C1 transfer
        push_xfer(8'hC0, 51);
        push_xfer(8'hC1, 160);
        cpu_cycle(16'hFF46, 1'b1, 8'hC0, rd);
        idle_cycles(50);
        cpu_cycle(16'hFF46, 1'b1, 8'hC1, rd);
        wait_idle("restart", 51 * 4 + 640);
        check("restart_oam0", 16'(oam[0]), 16'h00A5);
        check("restart_oam50", 16'(oam[50]), 16'h0097);
        check("restart_oam159", 16'(oam[159]), 16'h003A);

        // Reset mid-transfer at idx 80
        push_xfer(8'hC0, 80);
        cpu_cycle(16'hFF46, 1'b1, 8'hC0, rd);
        idle_cycles(80);
        s0 = n_strobe;
        reset_n  = 1'b0;
        cpu_addr = 16'hFF46;
        repeat (2) @(negedge clock);
        check("midrst_active", 16'(dma_active), 16'd0);
        check("midrst_ff46", 16'(cpu_data_out), 16'h00FF);
        reset_n  = 1'b1;
        cpu_addr = 16'h0000;
        repeat (800) @(negedge clock);
        check("midrst_no_strobes", 16'(n_strobe - s0), 16'd0);
        check("midrst_active_after", 16'(dma_active), 16'd0);
        check("midrst_queue_empty", 16'(exp_q.size()), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/oam_dma_controller.md
# oam_dma_controller

Sequencer and bus arbiter for the Game Boy OAM DMA transfer (register FF46). It sits between the CPU and the `memory` block's CPU-side bus and owns the FF46 register. On a write to FF46 it copies 160 bytes from `{FF46, 8'h00}` into OAM through a dedicated OAM write port. During the copy it time-shares the memory bus with the CPU and restricts the CPU to HRAM.

## Interface
Parameters:
- XFER_LEN, 160, number of bytes copied per transfer.
- DMA_REG_ADDR, 16'hFF46, CPU address of the DMA source register.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  reset; one clock, synchronous, active-low.
- cpu_addr  in  16  CPU address; held stable for a whole M-cycle.
- cpu_wren  in  1  CPU write enable.
- cpu_data_in  in  8  CPU write data.
- cpu_data_out  out  8  read data returned to the CPU.
- mem_addr  out  16  address to the memory block's CPU port.
- mem_wren  out  1  write enable to the memory block's CPU port.
- mem_data_in  out  8  write data to the memory block; always equals cpu_data_in.
- mem_data_out  in  8  read data from the memory block; valid one clock after the address is presented.
- oam_dma_addr  out  8  OAM write index.
- oam_dma_data  out  8  OAM write data.
- oam_dma_wren  out  1  OAM write strobe.
- dma_active  out  1  high while a transfer is in progress.
- m_phase  out  2  free-running clock phase within an M-cycle (0..3), used for CPU alignment.

## Operation
- `m_phase` increments every clock and wraps 3→0.
- The DMA register is 8 bits and resets to 8'hFF.
- **Register write.** Occurs when `cpu_wren` is high, `cpu_addr == DMA_REG_ADDR` and `m_phase == 3`. A write is accepted in any state, including while a transfer is active.
- **Register read.** When `cpu_addr == DMA_REG_ADDR`, `cpu_data_out` = register value, in both states.
- **Source address.**
  - High byte: the register value; if the value is > 8'hDF, use value − 8'h20.
  - Low byte: the byte index.
- **States.**
  - IDLE: bus fully transparent. `mem_addr = cpu_addr`, `mem_wren = cpu_wren`, `cpu_data_out = mem_data_out` (except the FF46 read above).
  - ACTIVE: entered at the phase-0 clock following a register write. `idx` = 0 at entry.
- **Per byte in ACTIVE, one M-cycle each:**
  - Phase 0: `mem_addr` = source address, `mem_wren` = 0.
  - Phase 1: `mem_addr` is still the source address. On the clock edge ending phase 1, latch `mem_data_out` into `oam_dma_data`.
  - Phase 2: `oam_dma_addr = idx`, `oam_dma_wren = 1`.
  - Phase 3: `idx` increments. If the incremented `idx` equals XFER_LEN, return to IDLE at the next clock.
- **CPU during ACTIVE.**
  - Phases 2–3: `mem_addr = cpu_addr`.
  - `mem_wren = cpu_wren` only in phase 3 and only when `cpu_addr` is in FF80–FFFE; otherwise 0.
  - `cpu_data_out = mem_data_out` for FF80–FFFE, the register value for FF46, and 8'hFF for all other addresses, in every phase.
  - CPU writes outside HRAM and FF46 are dropped.
- **Restart.** A register write while ACTIVE loads the new value. The transfer restarts at `idx` 0 at the next phase 0. Bytes already written remain in OAM.
- **Arithmetic.** `idx` is 8 bits, range 0..XFER_LEN−1, and never exceeds 159.

## Timing
- **Reset values (`reset_n` low at a rising edge):**
  - `m_phase` = 0, `dma_active` = 0, state = IDLE, register = 8'hFF.
  - `oam_dma_wren` = 0, `oam_dma_addr` = 0, `oam_dma_data` = 0.
  - Reset mid-transfer aborts immediately; no further OAM writes occur.
- **Start latency.** A register write committed at phase 3 of M-cycle N sets `dma_active` = 1 at phase 0 of M-cycle N+1.
- **Duration.** `dma_active` stays high for exactly XFER_LEN × 4 = 640 clocks with no restart.
- **OAM write.** Byte k is written at phase 2 of active M-cycle k. `oam_dma_wren` is high for exactly one clock per byte, 160 strobes total.
- **CPU HRAM read during ACTIVE.** Address presented at phase 2; data valid at phase 3.
- **Simultaneous events.** On the last byte's phase 3, a coincident register write restarts the transfer: ACTIVE continues with `idx` = 0 and no IDLE gap.
- `mem_wren` is combinational. All other outputs are registered except `cpu_data_out` and `mem_addr`.

## Test plan
- **Reset.** Hold `reset_n` low 3 clocks → `dma_active` = 0, `oam_dma_wren` = 0, FF46 reads 8'hFF, `m_phase` = 0 after release.
- **Basic transfer.** Preload C000–C09F with pattern i^8'h5A. Write 8'hC0 to FF46 → 160 OAM strobes, `oam_dma_addr` 0..159, data i^8'h5A. `dma_active` high for 640 clocks starting at the next phase 0.
- **CPU isolation.** During the transfer:
  - CPU reads C010 → 8'hFF.
  - CPU writes 8'h77 to C020 → C020 unchanged after DMA.
  - CPU writes 8'h33 to FF90 then reads it back → 8'h33.
- **Source clamp.** Write 8'hE1 → source reads from C100–C19F.
- **Restart.** Write 8'hC0; at `idx` 50 write 8'hC1 → `idx` resets to 0. The final OAM holds C100–C19F data, and `dma_active` stays high 640 clocks after the second write's following phase 0.
- **Reset mid-transfer.** Assert `reset_n` at `idx` 80 → no OAM strobes afterward, `dma_active` = 0, register = 8'hFF.
